mixcolumn_sequencer: RTL and testbench



---
 rtl/aes_pkg.sv | 54 +++++
 rtl/mixcolumn_word.sv | 33 +++
 rtl/mixcolumn_sequencer.sv | 93 +++++++++
 tb/tb_mixcolumn_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns arithmetic: GF(2^8) constant multipliers, coefficient rows and the sequencer FSM states.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_e;

  // Row-0 coefficients for a0..a3. Row r uses the same row rotated right by r.
  localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul02(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul03(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Only ever called with constant c, so each call folds to a single multiplier.
  function automatic logic [7:0] gf_mulc(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] p;
    case (c)
      8'h01:   p = b;
      8'h02:   p = mul02(b);
      8'h03:   p = mul03(b);
      8'h09:   p = mul09(b);
      8'h0b:   p = mul0b(b);
      8'h0d:   p = mul0d(b);
      8'h0e:   p = mul0e(b);
      default: p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mixcolumn_word.sv
// Combinational single-column MixColumns, forward or inverse.
// Byte [31:24] is row 0; output uses the same order.
module mixcolumn_word
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inverse,
  output logic [31:0] o_col
);

  logic [7:0] w_a   [4];
  logic [7:0] w_fwd [4];
  logic [7:0] w_inv [4];

  always_comb begin
    w_a[0] = i_col[31:24];
    w_a[1] = i_col[23:16];
    w_a[2] = i_col[15:8];
    w_a[3] = i_col[7:0];
    for (int r = 0; r < 4; r++) begin
      w_fwd[2'(r)] = 8'h00;
      w_inv[2'(r)] = 8'h00;
      for (int k = 0; k < 4; k++) begin
        w_fwd[2'(r)] = w_fwd[2'(r)] ^ gf_mulc(w_a[2'(k)], FWD_COEF[2'(k - r)]);
        w_inv[2'(r)] = w_inv[2'(r)] ^ gf_mulc(w_a[2'(k)], INV_COEF[2'(k - r)]);
      end
    end
  end

  assign o_col = i_inverse ? {w_inv[0], w_inv[1], w_inv[2], w_inv[3]}
                           : {w_fwd[0], w_fwd[1], w_fwd[2], w_fwd[3]};

endmodule

// File: rtl/mixcolumn_sequencer.sv
// Folds a 128-bit MixColumns onto one shared column unit, one column per cycle.
// Accept-to-out_valid is 4 cycles; result is held in DONE until out_ready, with same-cycle re-accept.
module mixcolumn_sequencer
  import aes_pkg::*;
#(
  parameter logic ENABLE_INV = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_inverse,
  input  logic [31:0] in_statew1,
  input  logic [31:0] in_statew2,
  input  logic [31:0] in_statew3,
  input  logic [31:0] in_statew4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_statew1,
  output logic [31:0] out_statew2,
  output logic [31:0] out_statew3,
  output logic [31:0] out_statew4,
  output logic        busy
);

  state_e      r_state;
  state_e      w_next;
  logic [1:0]  r_col_idx;
  logic        r_mode;
  logic [31:0] r_cols [4];
  logic        w_accept;
  logic [31:0] w_mix_in;
  logic [31:0] w_mix_out;

  assign in_ready = reset_n & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = MIX;
      MIX:  if (r_col_idx == 2'd3) w_next = DONE;
      DONE: begin
        if (w_accept) w_next = MIX;
        else if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_mix_in = r_cols[r_col_idx];

  mixcolumn_word u_mix (
    .i_col     (w_mix_in),
    .i_inverse (r_mode),
    .o_col     (w_mix_out)
  );

  // Accept can only happen in IDLE or DONE, so it never collides with a MIX write-back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_col_idx <= 2'd0;
      r_mode    <= 1'b0;
      for (int i = 0; i < 4; i++) r_cols[i] <= 32'h0;
    end else if (w_accept) begin
      r_col_idx <= 2'd0;
      r_mode    <= in_inverse & ENABLE_INV;
      r_cols[0] <= in_statew1;
      r_cols[1] <= in_statew2;
      r_cols[2] <= in_statew3;
      r_cols[3] <= in_statew4;
    end else if (r_state == MIX) begin
      r_cols[r_col_idx] <= w_mix_out;
      r_col_idx         <= r_col_idx + 2'd1;
    end
  end

  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign out_statew1 = r_cols[0];
  assign out_statew2 = r_cols[1];
  assign out_statew3 = r_cols[2];
  assign out_statew4 = r_cols[3];

endmodule

// File: tb/tb_mixcolumn_sequencer.sv
// Bench for mixcolumn_sequencer: directed vectors plus a queue-based reference model checked every cycle.
module tb_mixcolumn_sequencer;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] DB_IN    = {4{32'hdb135345}};
  localparam logic [127:0] DB_OUT   = {4{32'h8e4da1bc}};
  localparam logic [127:0] C6_ST    = {4{32'hc6c6c6c6}};
  localparam logic [127:0] ONE_ST   = {4{32'h01010101}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, in_ready, in_inverse, out_valid, out_ready, busy;
  logic [31:0] in_statew1, in_statew2, in_statew3, in_statew4;
  logic [31:0] out_statew1, out_statew2, out_statew3, out_statew4;

  logic        ni_in_valid, ni_in_ready, ni_in_inverse, ni_out_valid, ni_busy;
  logic [31:0] ni_in_w1, ni_in_w2, ni_in_w3, ni_in_w4;
  logic [31:0] ni_out_w1, ni_out_w2, ni_out_w3, ni_out_w4;

  mixcolumn_sequencer u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
    .in_statew1(in_statew1), .in_statew2(in_statew2), .in_statew3(in_statew3), .in_statew4(in_statew4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_statew1(out_statew1), .out_statew2(out_statew2), .out_statew3(out_statew3), .out_statew4(out_statew4),
    .busy(busy)
  );

  mixcolumn_sequencer #(.ENABLE_INV(1'b0)) u_dut_ni (
    .clk(clk), .reset_n(reset_n),
    .in_valid(ni_in_valid), .in_ready(ni_in_ready), .in_inverse(ni_in_inverse),
    .in_statew1(ni_in_w1), .in_statew2(ni_in_w2), .in_statew3(ni_in_w3), .in_statew4(ni_in_w4),
    .out_valid(ni_out_valid), .out_ready(1'b1),
    .out_statew1(ni_out_w1), .out_statew2(ni_out_w2), .out_statew3(ni_out_w3), .out_statew4(ni_out_w4),
    .busy(ni_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  // Reference arithmetic: generic shift-and-add GF(2^8) multiply and explicit matrices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] w, input logic inv);
    logic [7:0] fm [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                              '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    logic [7:0] im [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                              '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    logic [7:0] a [4];
    logic [7:0] r [4];
    a = '{w[31:24], w[23:16], w[15:8], w[7:0]};
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] ^= gmul(a[j], inv ? im[i][j] : fm[i][j]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s, input logic inv);
    return {ref_col(s[127:96], inv), ref_col(s[95:64], inv), ref_col(s[63:32], inv), ref_col(s[31:0], inv)};
  endfunction

  // Scoreboard: each accepted state is due 5 negedges (4 clocks) after its accept decision.
  logic [127:0] exp_q [$];
  int           acc_q [$];

  always @(negedge clk) begin
    logic exp_valid, exp_in_ready;
    if (!reset_n) begin
      chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
      exp_q.delete();
      acc_q.delete();
    end else begin
      exp_valid    = (exp_q.size() > 0) && (cyc - acc_q[0] >= 5);
      exp_in_ready = (exp_q.size() == 0) || (exp_valid && out_ready);
      chk("sb_out_valid", {127'b0, out_valid}, {127'b0, exp_valid});
      chk("sb_busy", {127'b0, busy}, {127'b0, exp_q.size() > 0});
      chk("sb_in_ready", {127'b0, in_ready}, {127'b0, exp_in_ready});
      if (exp_valid) begin
        chk("sb_data", {out_statew1, out_statew2, out_statew3, out_statew4}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (in_valid && exp_in_ready) begin
        exp_q.push_back(ref_state({in_statew1, in_statew2, in_statew3, in_statew4}, in_inverse));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [127:0] s, input logic inv);
    {in_statew1, in_statew2, in_statew3, in_statew4} = s;
    in_inverse = inv;
  endtask

  task automatic send(input logic [127:0] s, input logic inv, output int acc);
    bit ok = 0;
    acc = 0;
    set_in(s, inv);
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok  = 1;
        acc = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) timeout("send");
  endtask

  // Leaves the caller on the negedge where out_valid is first seen.
  task automatic wait_valid(output int seen);
    bit ok = 0;
    seen = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok   = 1;
        seen = cyc;
      end
    end
    if (!ok) timeout("wait_out_valid");
  endtask

  logic [127:0] cap;
  logic [127:0] bb [3];
  int a, c, prev;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(128'h0, 1'b0);
    ni_in_valid = 1'b0; ni_in_inverse = 1'b0;
    {ni_in_w1, ni_in_w2, ni_in_w3, ni_in_w4} = 128'h0;

    chk("model_fips_fwd", ref_state(FIPS_IN, 1'b0), FIPS_OUT);
    chk("model_fips_inv", ref_state(FIPS_OUT, 1'b1), FIPS_IN);
    chk("model_db_fwd", {96'h0, ref_col(32'hdb135345, 1'b0)}, {96'h0, 32'h8e4da1bc});
    chk("model_c6_inv", ref_state(C6_ST, 1'b1), C6_ST);

    repeat (3) tick();
    @(negedge clk);
    chk("rst_outputs", {out_statew1, out_statew2, out_statew3, out_statew4}, 128'h0);
    chk("rst_flags", {126'b0, out_valid, busy}, 128'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {127'b0, in_ready}, 128'd1);
    tick();

    send(FIPS_IN, 1'b0, a);
    wait_valid(c);
    chk("fips_latency", 128'(c - a), 128'd5);
    chk("fips_fwd", {out_statew1, out_statew2, out_statew3, out_statew4}, FIPS_OUT);
    tick();

    send(FIPS_OUT, 1'b1, a);
    wait_valid(c);
    chk("fips_inv", {out_statew1, out_statew2, out_statew3, out_statew4}, FIPS_IN);
    tick();
    send(DB_IN, 1'b0, a);
    wait_valid(c);
    chk("db_fwd", {out_statew1, out_statew2, out_statew3, out_statew4}, DB_OUT);
    tick();
    send(DB_OUT, 1'b1, a);
    wait_valid(c);
    chk("db_inv", {out_statew1, out_statew2, out_statew3, out_statew4}, DB_IN);
    tick();

    // Backpressure, with a second state already waiting on the input.
    out_ready = 1'b0;
    send(128'h01234567_89abcdef_fedcba98_76543210, 1'b0, a);
    set_in(128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1'b1);
    in_valid = 1'b1;
    wait_valid(c);
    cap = {out_statew1, out_statew2, out_statew3, out_statew4};
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_data", {out_statew1, out_statew2, out_statew3, out_statew4}, cap);
      chk("bp_hold_flags", {126'b0, out_valid, in_ready}, 128'd2);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {126'b0, out_valid, in_ready}, 128'd3);
    tick();
    in_valid = 1'b0;
    wait_valid(c);
    tick();

    // Back-to-back: accepts every 5 cycles.
    bb[0] = FIPS_IN; bb[1] = C6_ST; bb[2] = ONE_ST;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      send(bb[k], 1'b0, a);
      if (k > 0) chk("b2b_spacing", 128'(a - prev), 128'd5);
      prev = a;
    end
    wait_valid(c);
    chk("b2b_last", {out_statew1, out_statew2, out_statew3, out_statew4}, ONE_ST);
    tick();

    // Abort during MIX with col = 2.
    send(FIPS_IN, 1'b0, a);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_outputs", {out_statew1, out_statew2, out_statew3, out_statew4}, 128'h0);
    chk("abort_flags", {126'b0, out_valid, busy}, 128'd0);
    tick();
    reset_n = 1'b1;
    send(DB_IN, 1'b0, a);
    wait_valid(c);
    chk("post_abort", {out_statew1, out_statew2, out_statew3, out_statew4}, DB_OUT);
    tick();

    // Inverse disabled: in_inverse must be ignored.
    {ni_in_w1, ni_in_w2, ni_in_w3, ni_in_w4} = DB_IN;
    ni_in_inverse = 1'b1;
    ni_in_valid   = 1'b1;
    @(negedge clk);
    chk("ni_in_ready", {127'b0, ni_in_ready}, 128'd1);
    tick();
    ni_in_valid = 1'b0;
    begin
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (ni_out_valid) ok = 1;
      end
      if (!ok) timeout("ni_wait");
      else chk("ni_forward", {ni_out_w1, ni_out_w2, ni_out_w3, ni_out_w4}, DB_OUT);
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
